// File: rtl/seg_reader.sv
// Seven-segment bus loop-back decoder: synchronizes segment/anode lines, waits for a stable
// digit, decodes it and emits it over a one-entry valid/ready register. SEG_READER_HEX_EN enables A-F.
module seg_reader #(
    parameter int DIGITS         = 4,
    parameter int STABLE_CYCLES  = 8,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic                                           a,
    input  logic                                           b,
    input  logic                                           c,
    input  logic                                           d,
    input  logic                                           e,
    input  logic                                           f,
    input  logic                                           g,
    input  logic                                           dp,
    input  logic [DIGITS-1:0]                              an,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [3:0]                                     out_data,
    output logic                                           out_dp,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] out_idx,
    output logic                                           out_err,
    output logic                                           overflow
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam bit SAL = (SEG_ACTIVE_LOW != 0);
    localparam logic [6:0] SEG_OFF = SAL ? 7'h7F : 7'h00;
    localparam logic [CW-1:0] CNT_DONE = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef struct packed {
        logic          vld;
        logic [IW-1:0] idx;
        logic [6:0]    seg;
        logic          dp;
    } samp_t;

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

    // Synchronizer resets to the raw "unlit / no anode" line levels
    logic [1:0][6:0]        seg_s;
    logic [1:0]             dp_s;
    logic [1:0][DIGITS-1:0] an_s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_s <= {2{SEG_OFF}};
            dp_s  <= {2{SAL}};
            an_s  <= '1;
        end else begin
            seg_s <= {seg_s[0], {g, f, e, d, c, b, a}};
            dp_s  <= {dp_s[0], dp};
            an_s  <= {an_s[0], an};
        end
    end

    logic [DIGITS-1:0] an_on;
    samp_t             cur;

    always_comb begin
        an_on   = ~an_s[1];
        cur     = '0;
        cur.vld = (an_on != '0) && ((an_on & (an_on - DIGITS'(1))) == '0);
        for (int i = 0; i < DIGITS; i++)
            if (an_on[i]) cur.idx = i[IW-1:0];
        cur.seg = SAL ? ~seg_s[1] : seg_s[1];
        cur.dp  = SAL ? ~dp_s[1] : dp_s[1];
    end

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    samp_t         prev, held, held_n;
    logic          cap;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            prev  <= '0;
            held  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            prev  <= cur;
            held  <= held_n;
        end
    end

    // held latches the sample on the edge the count completes; CAPTURE/HOLD work from it
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        held_n  = held;
        cap     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (cur.vld) begin
                    cnt_n   = CNT_ONE;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (!cur.vld) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (cur == prev) begin
                    cnt_n = cnt + CNT_ONE;
                end else begin
                    cnt_n = CNT_ONE;
                end
            end
            CAPTURE: begin
                cap     = 1'b1;
                state_n = HOLD;
            end
            HOLD: begin
                if (!cur.vld) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (cur != held) begin
                    cnt_n   = CNT_ONE;
                    state_n = SETTLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (state_n == SETTLE && cnt_n >= CNT_DONE) begin
            state_n = CAPTURE;
            held_n  = cur;
        end
    end

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F: decode = 5'h00;
            7'h06: decode = 5'h01;
            7'h5B: decode = 5'h02;
            7'h4F: decode = 5'h03;
            7'h66: decode = 5'h04;
            7'h6D: decode = 5'h05;
            7'h7D: decode = 5'h06;
            7'h07: decode = 5'h07;
            7'h7F: decode = 5'h08;
            7'h6F: decode = 5'h09;
`ifdef SEG_READER_HEX_EN
            7'h77: decode = 5'h0A;
            7'h7C: decode = 5'h0B;
            7'h39: decode = 5'h0C;
            7'h5E: decode = 5'h0D;
            7'h79: decode = 5'h0E;
            7'h71: decode = 5'h0F;
`endif
            default: decode = 5'h10;
        endcase
    endfunction

    logic [4:0] dec;
    assign dec = decode(held.seg);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_dp    <= 1'b0;
            out_idx   <= '0;
            out_err   <= 1'b0;
            overflow  <= 1'b0;
        end else if (cap) begin
            if (!out_valid || out_ready) begin
                out_valid <= 1'b1;
                out_data  <= dec[3:0];
                out_err   <= dec[4];
                out_dp    <= held.dp;
                out_idx   <= held.idx;
            end else begin
                overflow <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seg_reader.sv
// Scoreboard bench for seg_reader: expected digits are queued when a pattern is driven and
// compared when the DUT hands them over.
module tb_seg_reader;
    localparam int DIGITS = 4;
    localparam int S      = 8;
    localparam int SAL    = 0;
    localparam int IW     = 2;

    logic clock = 1'b0;
    logic reset;
    logic a, b, c, d, e, f, g, dp;
    logic [DIGITS-1:0] an;
    logic out_valid, out_ready, out_dp, out_err, overflow;
    logic [3:0] out_data;
    logic [IW-1:0] out_idx;

    typedef struct packed {
        logic [3:0]    data;
        logic          dp;
        logic [IW-1:0] idx;
        logic          err;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int hs = 0;

    seg_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(S), .SEG_ACTIVE_LOW(SAL)) dut (
        .clock(clock), .reset(reset),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp), .an(an),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dp(out_dp), .out_idx(out_idx), .out_err(out_err), .overflow(overflow)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        exp_t x;
        if (!reset && out_valid && out_ready) begin
            hs++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output data=%0d idx=%0d err=%0d", out_data, out_idx, out_err);
            end else begin
                x = q.pop_front();
                if ({out_data, out_dp, out_idx, out_err} !== x) begin
                    errors++;
                    $display("FAIL output got data=%0d dp=%0d idx=%0d err=%0d exp data=%0d dp=%0d idx=%0d err=%0d",
                             out_data, out_dp, out_idx, out_err, x.data, x.dp, x.idx, x.err);
                end
            end
        end
    end

    task automatic drive(input logic [6:0] pat, input logic dpv, input logic [DIGITS-1:0] anv);
        {g, f, e, d, c, b, a} = (SAL != 0) ? ~pat : pat;
        dp = (SAL != 0) ? ~dpv : dpv;
        an = anv;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push(input int data, input logic dpv, input int idx, input logic err);
        exp_t x;
        x.data = data[3:0];
        x.dp   = dpv;
        x.idx  = idx[IW-1:0];
        x.err  = err;
        q.push_back(x);
    endtask

    task automatic idle();
        drive(7'h00, 1'b0, '1);
        cycles(5);
    endtask

    task automatic test_reset();
        int n;
        out_ready = 1'b0;
        drive(7'h66, 1'b0, 4'b0111);
        cycles(15);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'd4 || out_idx !== 2'd3) begin
            errors++;
            $display("FAIL pre_reset_hold got v=%0d data=%0d idx=%0d exp v=1 data=4 idx=3", out_valid, out_data, out_idx);
        end
        drive(7'h5B, 1'b0, 4'b1110);
        cycles(5);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %0d exp 0", out_valid);
        end
        checks++;
        if ({out_data, out_dp, out_idx, out_err, overflow} !== 9'd0) begin
            errors++;
            $display("FAIL reset_fields got data=%0d dp=%0d idx=%0d err=%0d ovf=%0d exp all 0",
                     out_data, out_dp, out_idx, out_err, overflow);
        end
        cycles(2);
        out_ready = 1'b1;
        push(2, 1'b0, 0, 1'b0);
        reset = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clock);
            #1 n++;
        end
        checks++;
        if (n != S + 3) begin
            errors++;
            $display("FAIL reset_latency got %0d edges exp %0d", n, S + 3);
        end
        cycles(2);
        idle();
    endtask

    task automatic test_scan();
        logic [6:0] pats [4];
        logic [3:0] anv;
        int base;
        pats[0] = 7'h06; pats[1] = 7'h5B; pats[2] = 7'h4F; pats[3] = 7'h66;
        base = hs;
        for (int i = 0; i < 4; i++) begin
            anv = ~(4'b0001 << i);
            push(i + 1, (i == 2), i, 1'b0);
            drive(pats[i], (i == 2), anv);
            cycles(20);
        end
        idle();
        checks++;
        if (hs - base != 4) begin
            errors++;
            $display("FAIL scan_count got %0d exp 4", hs - base);
        end
    endtask

    task automatic test_glitch();
        int n;
        int base;
        base = hs;
        push(1, 1'b0, 0, 1'b0);
        drive(7'h06, 1'b0, 4'b1110);
        cycles(5);
        drive(7'h04, 1'b0, 4'b1110);
        cycles(1);
        drive(7'h06, 1'b0, 4'b1110);
        n = 6;
        while (out_valid !== 1'b1 && n < 60) begin
            @(posedge clock);
            #1 n++;
        end
        checks++;
        if (n != 6 + S + 3) begin
            errors++;
            $display("FAIL glitch_latency got %0d edges exp %0d", n, 6 + S + 3);
        end
        cycles(12);
        checks++;
        if (hs - base != 1) begin
            errors++;
            $display("FAIL glitch_count got %0d exp 1", hs - base);
        end
        idle();
    endtask

    task automatic test_invalid();
        int base;
        int seen;
        base = hs;
        seen = 0;
        drive(7'h06, 1'b0, 4'b1100);
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || hs != base) begin
            errors++;
            $display("FAIL two_anodes got %0d valid cycles exp 0", seen);
        end
        push(0, 1'b0, 0, 1'b1);
        drive(7'h00, 1'b0, 4'b1110);
        cycles(15);
        idle();
        checks++;
        if (hs - base != 1) begin
            errors++;
            $display("FAIL blank_count got %0d exp 1", hs - base);
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_initial got %0d exp 0", overflow);
        end
        drive(7'h3F, 1'b0, 4'b1110);
        cycles(15);
        drive(7'h4F, 1'b0, 4'b1101);
        cycles(15);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'd0 || out_idx !== 2'd0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_hold got v=%0d data=%0d idx=%0d ovf=%0d exp v=1 data=0 idx=0 ovf=1",
                     out_valid, out_data, out_idx, overflow);
        end
        push(0, 1'b0, 0, 1'b0);
        out_ready = 1'b1;
        cycles(3);
        checks++;
        if (overflow !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sticky got ovf=%0d v=%0d exp ovf=1 v=0", overflow, out_valid);
        end
        idle();
    endtask

    task automatic test_hex();
`ifdef SEG_READER_HEX_EN
        push(10, 1'b1, 2, 1'b0);
`else
        push(0, 1'b1, 2, 1'b1);
`endif
        drive(7'h77, 1'b1, 4'b1011);
        cycles(15);
        idle();
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b0;
        drive(7'h00, 1'b0, '1);
        cycles(3);
        reset = 1'b0;
        test_reset();
        test_scan();
        test_glitch();
        test_invalid();
        test_hex();
        test_overflow();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d pending exp 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_reader.md
# seg_reader

Sequential decoder for the seven-segment display bus: samples the multiplexed segment lines (a–g, dp) and active-low digit anodes driven by the display path, filters glitches, and recovers the 4-bit value and decimal point of each scanned digit. Each recovered digit is emitted over a one-entry valid/ready output register. The block sits on the board's display bus as a loop-back monitor and self-check, closing the data → segments path in the opposite direction.

## Interface
- `DIGITS`, 4: number of multiplexed digits (anode lines), 1–8.
- `STABLE_CYCLES`, 8: consecutive cycles a synchronized pattern and anode must hold before capture, ≥1.
- `SEG_ACTIVE_LOW`, 0: 1 = segment lit when its line is 0; 0 = lit when 1.

- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`,`dp`  in  1 each  segment lines, polarity per `SEG_ACTIVE_LOW`.
- `an`  in  DIGITS  anode selects, active-low; bit i low = digit i shown.
- `out_valid`  out  1  output register holds an unconsumed digit.
- `out_ready`  in  1  consumer accepts on `out_valid && out_ready`.
- `out_data`  out  4  decoded value, 0 when `out_err`.
- `out_dp`  out  1  decimal point lit.
- `out_idx`  out  max(1,$clog2(DIGITS))  digit index of the capture.
- `out_err`  out  1  pattern not in the decode table.
- `overflow`  out  1  sticky: a capture was dropped.

## Operation
- All inputs pass through a 2-flop synchronizer; segments are normalized to lit = 1, packed {g,f,e,d,c,b,a}.
- Select is valid only when exactly one `an` bit is low. Zero or multiple low → no digit selected.
- FSM:
  - IDLE: no valid select; counter cleared. Valid select → SETTLE, counter = 1.
  - SETTLE: per cycle, if {select, pattern, dp} equals the previous cycle, count++; otherwise counter = 1 and stay in SETTLE. Select becomes invalid → IDLE. Count reaches `STABLE_CYCLES` → CAPTURE.
  - CAPTURE (one cycle): decode and present to the output register, then → HOLD.
  - HOLD: no further captures until select or pattern changes. Change to another valid select or pattern → SETTLE (counter = 1). Select becomes invalid → IDLE.
- Decode table, lit-segment bytes: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. Any other byte sets `out_err=1`, `out_data=0`. `dp` passes through to `out_dp` in both cases.
- Output register, evaluated at a capture:
  - Empty, or full with `out_ready=1` in the same cycle → load the new digit; `out_valid=1`.
  - Full with `out_ready=0` → keep the old contents, drop the new digit, set `overflow=1`.
- Without a capture, `out_valid && out_ready` clears `out_valid` on the next edge. Output fields hold their values while `out_valid=1`.
- `overflow` clears only on reset.

## Timing
- Reset (asynchronous, mid-operation included): FSM = IDLE, counter = 0, synchronizer flops = all segments unlit and all anodes inactive, `out_valid`/`out_data`/`out_dp`/`out_idx`/`out_err`/`overflow` = 0. First capture after reset release needs a full settle.
- Latency: inputs change before edge 0 and then hold → `out_valid` rises after edge `STABLE_CYCLES+3`. This breaks down as 2 synchronizer edges, `STABLE_CYCLES` settle edges (counting from 1), and 1 capture edge.
- A single-cycle glitch in any synchronized input restarts the count.
- Throughput: at most one capture per `STABLE_CYCLES+1` cycles.

## Configuration
- `SEG_READER_HEX_EN` defined: patterns A–F (77,7C,39,5E,79,71) decode to values 10–15 with `out_err=0`.
- Not defined: only 0–9 are valid; the A–F patterns give `out_err=1`, `out_data=0`.

## Test plan
- Reset mid-SETTLE with `an=1110` and pattern 5B held → all outputs 0; after release, `out_valid` rises `STABLE_CYCLES+3` edges later with `out_data=2`, `out_idx=0`, `out_err=0`.
- Scan digits 0–3 showing 1,2,3,4 (`dp` on digit 2), each held 20 cycles, `out_ready=1` → four outputs in order: data 1,2,3,4; idx 0,1,2,3; `out_dp` high only for idx 2; one capture per digit.
- Pattern 06 with a one-cycle flip of segment `b` at settle count 5 → count restarts; single capture of 1, delayed by the glitch.
- `an=1100` (two digits low) held 30 cycles → no capture; pattern 00 (blank) on a single digit → `out_err=1`, `out_data=0`.
- `out_ready=0` with two digits captured back-to-back → first held in the register, second dropped, `overflow=1` stays set after `out_ready` returns to 1.
- Pattern 77 → with `SEG_READER_HEX_EN`: `out_data=10`, `out_err=0`; without it: `out_data=0`, `out_err=1`.
